// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state types and operand-signedness helpers for mdu_iter.
package mdu_pkg;
   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } mdu_op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
   function automatic logic a_signed(input mdu_op_e op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction
   function automatic logic b_signed(input mdu_op_e op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction
   function automatic logic is_div(input mdu_op_e op);
      return op[2];
   endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem      partial remainder in      div      divisor magnitude
//   din      next dividend bit         rem_next partial remainder out
//   q        quotient bit produced by this step
module mdu_div_step #(parameter int XLEN = 32) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] div,
   input  logic            din,
   output logic [XLEN-1:0] rem_next,
   output logic            q
);
   logic [XLEN:0]   part;
   logic [XLEN-1:0] diff;
   assign part = {rem, din};
   // when the subtraction succeeds the difference is below div, so XLEN bits suffice
   assign diff = part[XLEN-1:0] - div;
   assign q = part >= {1'b0, div};
   assign rem_next = q ? diff : part[XLEN-1:0];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with valid/ready on both sides.
//   clk, reset (sync, active-high)
//   in_valid/in_ready, op (funct3), a, b : request side
//   out_valid/out_ready, result          : response side
//   busy                                  : high whenever not IDLE
// Define MDU_FAST_MUL_EN to resolve the four multiply ops in one cycle.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N);
   mdu_state_e state, state_n;
   mdu_op_e op_e, op_q;
   logic accept, early, fast, last, div_zero, ovf, sa, sb, neg_q, neg_r;
   logic [CW-1:0] cnt;
   logic [XLEN-1:0] mb, early_res, fin_res, quo_f, rem_f;
   logic [2*XLEN-1:0] acc, acc_n, mul_n, fix;
   logic [XLEN-1:0] rem_c [UNROLL+1];
   logic [XLEN-1:0] quo_c [UNROLL+1];
   logic [UNROLL-1:0] qbit;
   assign op_e = mdu_op_e'(op);
   assign accept = in_valid && in_ready;
   assign sa = a_signed(op_e) && a[XLEN-1];
   assign sb = b_signed(op_e) && b[XLEN-1];
   assign div_zero = is_div(op_e) && b == '0;
   assign ovf = op_e inside {DIV, REM} && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
   assign last = cnt == CW'(N - 1);
`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fprod;
   // sign-extended operands make the truncated product the correct signed result
   assign fprod = {{XLEN{sa}}, a} * {{XLEN{sb}}, b};
   assign fast = !is_div(op_e);
   assign early_res = div_zero ? (op[1] ? a : '1) :
                      ovf      ? (op[1] ? '0 : a) :
                      op_e == MUL ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
   assign fast = 1'b0;
   assign early_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
`endif
   assign early = div_zero || ovf || fast;
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = state == IDLE ? (accept ? (early ? DONE : CALC) : IDLE) :
                state == CALC ? (last ? DONE : CALC) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
   always_comb begin
      in_ready  = state == IDLE && !reset;
      out_valid = state == DONE;
      busy      = state != IDLE;
   end
   // shift-add multiply: acc holds {partial product, remaining multiplier bits}
   always_comb begin
      logic [XLEN:0] sum;
      sum = '0;
      mul_n = acc;
      for (int u = 0; u < UNROLL; u++) begin
         sum = {1'b0, mul_n[2*XLEN-1:XLEN]} + {1'b0, mb & {XLEN{mul_n[0]}}};
         mul_n = {sum, mul_n[XLEN-1:1]};
      end
   end
   // restoring divide: acc holds {partial remainder, dividend shifting into quotient}
   assign rem_c[0] = acc[2*XLEN-1:XLEN];
   assign quo_c[0] = acc[XLEN-1:0];
   for (genvar i = 0; i < UNROLL; i++) begin : g_div
      mdu_div_step #(.XLEN(XLEN)) step (
         .rem     (rem_c[i]),
         .div     (mb),
         .din     (quo_c[i][XLEN-1]),
         .rem_next(rem_c[i+1]),
         .q       (qbit[i])
      );
      assign quo_c[i+1] = {quo_c[i][XLEN-2:0], qbit[i]};
   end
   assign acc_n = is_div(op_q) ? {rem_c[UNROLL], quo_c[UNROLL]} : mul_n;
   assign fix   = neg_q ? -acc_n : acc_n;
   assign quo_f = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
   assign rem_f = neg_r ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
   assign fin_res = is_div(op_q) ? (op_q[1] ? rem_f : quo_f) :
                    op_q == MUL  ? fix[XLEN-1:0] : fix[2*XLEN-1:XLEN];
   always_ff @(posedge clk)
      if (reset) begin
         op_q   <= MUL;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         mb     <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (accept) begin
         op_q  <= op_e;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         mb    <= sb ? -b : b;
         acc   <= {{XLEN{1'b0}}, sa ? -a : a};
         cnt   <= '0;
         if (early) result <= early_res;
      end else if (state == CALC) begin
         acc <= acc_n;
         cnt <= cnt + CW'(1);
         if (last) result <= fin_res;
      end
endmodule
